imem_fetch: RTL and testbench

//   Parametrised synchronous-read instruction memory for the pipelined core.

---
 rtl/imem_fetch.sv | 155 +++++++++++++++
 tb/tb_imem_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch.sv
// Registered instruction memory behind a valid/ready fetch port.
// Provides programmable wait states, redirect flush, a backdoor load port and a bad-address flag.
module imem_fetch #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter int                LATENCY   = 1,
  parameter logic [DATA_W-1:0] INIT_WORD = {DATA_W{1'b0}},
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_s;
  logic [ADDR_W-1:0] addr_r;
  logic              accept;
  logic [ADDR_W-1:0] cap_addr_s;
  logic [IDX_W-1:0]  cap_idx_s;
  logic              cap_bad_s;
  logic              wr_bad_s;
  logic              wr_hit_s;

  logic [DATA_W-1:0] mem [DEPTH];

  // Misaligned, or any bit above the word index set: addresses never wrap.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    addr_bad = (a[1:0] != 2'b00) || ((a >> (IDX_W + 2)) != {ADDR_W{1'b0}});
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    addr_idx = a[IDX_W+1:2];
  endfunction

  // Power-up contents: fill value for every word.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = INIT_WORD;
    end
  end

  assign req_ready = !rst && (state_r == IDLE || state_r == RESP);
  assign accept    = req_valid && req_ready;

  // With LATENCY==1 the capture edge is the accept edge, so storage is addressed straight from the port.
  assign cap_addr_s = accept ? req_addr : addr_r;
  assign cap_idx_s  = addr_idx(cap_addr_s);
  assign cap_bad_s  = addr_bad(cap_addr_s);
  assign wr_bad_s   = addr_bad(wr_addr);
  assign wr_hit_s   = wr_en && !wr_bad_s && (addr_idx(wr_addr) == cap_idx_s);

  // Next-state logic for the single-outstanding fetch sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_s = RESP;
          end else begin
            state_s = WAIT;
            cnt_s   = CNT_INIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (flush) begin
          state_s = IDLE;
          cnt_s   = {CNT_W{1'b0}};
        end else if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = RESP;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sequencer state, wait counter and latched request address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (accept) begin
        addr_r <= req_addr;
      end
    end
  end

  // Response capture on every edge that enters RESP; a same-edge write to the same word wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_instr <= {DATA_W{1'b0}};
      rsp_addr  <= {ADDR_W{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= (state_s == RESP);
      if (state_s == RESP) begin
        rsp_addr <= cap_addr_s;
        rsp_err  <= cap_bad_s;
        if (cap_bad_s) begin
          rsp_instr <= {DATA_W{1'b0}};
        end else if (wr_hit_s) begin
          rsp_instr <= wr_data;
        end else begin
          rsp_instr <= mem[cap_idx_s];
        end
      end
    end
  end

  // Backdoor load port; independent of reset so programs can be loaded while the core is held.
  always @(posedge clk) begin
    if (wr_en && !wr_bad_s) begin
      mem[addr_idx(wr_addr)] <= wr_data;
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: three instances (LATENCY 1, 3, 4) share the write port and reset;
// a monitor pairs every response with the expectation queued when its request was accepted.
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  flush;
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_err;
  logic [31:0] req_addr  [3];
  logic [31:0] rsp_instr [3];
  logic [31:0] rsp_addr  [3];
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] exp_i [3];
  logic        exp_e [3];

  typedef struct {
    int          k;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } sb_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;
  int   rsp_cnt [3];
  int   run0;
  int   max_run0;

  always #5 clk = ~clk;

  imem_fetch #(.LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .flush(flush[0]), .rsp_valid(rsp_valid[0]),
    .rsp_instr(rsp_instr[0]), .rsp_addr(rsp_addr[0]), .rsp_err(rsp_err[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  imem_fetch #(.LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .flush(flush[1]), .rsp_valid(rsp_valid[1]),
    .rsp_instr(rsp_instr[1]), .rsp_addr(rsp_addr[1]), .rsp_err(rsp_err[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  imem_fetch #(.LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_addr(req_addr[2]), .flush(flush[2]), .rsp_valid(rsp_valid[2]),
    .rsp_instr(rsp_instr[2]), .rsp_addr(rsp_addr[2]), .rsp_err(rsp_err[2]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor, one time unit after each falling edge: score responses, apply flushes, queue accepts.
  always @(negedge clk) begin
    int  idx;
    sb_t e;
    #1;
    if (rst) begin
      sbq.delete();
      run0 = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (rsp_valid[k]) begin
          rsp_cnt[k]++;
          idx = -1;
          for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].k == k && idx < 0) idx = i;
          end
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp inst %0d: got addr %h, required no response", k, rsp_addr[k]);
          end else begin
            chk($sformatf("rsp_addr[%0d]", k), rsp_addr[k], sbq[idx].addr);
            chk($sformatf("rsp_instr[%0d]", k), rsp_instr[k], sbq[idx].instr);
            chk($sformatf("rsp_err[%0d]", k), {31'd0, rsp_err[k]}, {31'd0, sbq[idx].err});
            sbq.delete(idx);
          end
        end
        if (flush[k] && !req_ready[k]) begin
          idx = -1;
          for (int i = 0; i < sbq.size(); i++) begin
            if (sbq[i].k == k && idx < 0) idx = i;
          end
          if (idx >= 0) sbq.delete(idx);
        end
        if (req_valid[k] && req_ready[k]) begin
          e.k     = k;
          e.addr  = req_addr[k];
          e.instr = exp_i[k];
          e.err   = exp_e[k];
          sbq.push_back(e);
        end
      end
      run0 = rsp_valid[0] ? run0 + 1 : 0;
      if (run0 > max_run0) max_run0 = run0;
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Present a request and hold it until ready is seen; returns how many cycles it waited.
  task automatic send(input int k, input logic [31:0] a, input logic [31:0] ins,
                      input logic e, input logic fl, output int n);
    @(negedge clk);
    req_valid[k] = 1'b1; req_addr[k] = a; exp_i[k] = ins; exp_e[k] = e; flush[k] = fl;
    #2;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk); #2; n++;
    end
    if (!req_ready[k]) begin
      checks++;
      errors++;
      $display("FAIL send_timeout inst %0d: ready got 0 required 1", k);
    end
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    req_valid[k] = 1'b0;
    flush[k]     = 1'b0;
  endtask

  // Called on the accept cycle: counts cycles to rsp_valid and cycles with ready low.
  task automatic measure(input int k, output int cycles, output int low);
    idle(k);
    #2;
    cycles = 1;
    low    = 0;
    while (!rsp_valid[k] && cycles < 20) begin
      if (!req_ready[k]) low++;
      @(negedge clk); #2; cycles++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int n;
    int cyc;
    int low;
    int base;
    rst = 1'b1; req_valid = 3'b000; flush = 3'b000; wr_en = 1'b0;
    wr_addr = 32'd0; wr_data = 32'd0;
    for (int k = 0; k < 3; k++) begin
      req_addr[k] = 32'd0; exp_i[k] = 32'd0; exp_e[k] = 1'b0; rsp_cnt[k] = 0;
    end
    run0 = 0; max_run0 = 0;

    @(negedge clk); #2;
    for (int k = 0; k < 3; k++) begin
      chk("reset_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
      chk("reset_req_ready", {31'd0, req_ready[k]}, 32'd0);
      chk("reset_rsp_instr", rsp_instr[k], 32'd0);
      chk("reset_rsp_addr", rsp_addr[k], 32'd0);
      chk("reset_rsp_err", {31'd0, rsp_err[k]}, 32'd0);
    end

    // Program load while reset is held.
    wr(32'h0000_0000, 32'h8c08_0000);
    wr(32'h0000_0004, 32'h0108_4820);
    wr(32'h0000_0008, 32'h0108_5020);
    wr(32'h0000_003C, 32'h0800_0011);
    wr(32'h0000_004C, 32'h1111_1111);
    wr(32'h0000_0058, 32'h200b_002a);
    wr(32'h0000_03FC, 32'hdead_beef);
    wr(32'h0000_0028, 32'ha5a5_a5a5);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #2;
    for (int k = 0; k < 3; k++) chk("ready_after_reset", {31'd0, req_ready[k]}, 32'd1);

    // Back-to-back fetches on LATENCY=1, including the address-range boundaries.
    vecs[0] = '{32'h0000_0000, 32'h8c08_0000, 1'b0};
    vecs[1] = '{32'h0000_0004, 32'h0108_4820, 1'b0};
    vecs[2] = '{32'h0000_0008, 32'h0108_5020, 1'b0};
    vecs[3] = '{32'h0000_03FC, 32'hdead_beef, 1'b0};
    vecs[4] = '{32'h0000_0402, 32'h0000_0000, 1'b1};
    vecs[5] = '{32'h0000_0400, 32'h0000_0000, 1'b1};
    max_run0 = 0;
    for (int i = 0; i < 6; i++) begin
      send(0, vecs[i].addr, vecs[i].instr, vecs[i].err, 1'b0, n);
      chk("l1_ready_wait", n, 0);
    end
    idle(0);
    repeat (3) @(negedge clk);
    chk("l1_back_to_back_run", max_run0, 6);

    // LATENCY=3 timing.
    send(1, 32'h0000_003C, 32'h0800_0011, 1'b0, 1'b0, n);
    measure(1, cyc, low);
    chk("l3_latency", cyc, 3);
    chk("l3_ready_low_cycles", low, 2);
    repeat (2) @(negedge clk);

    // Redirect flush while waiting; the new request is taken once the block frees up.
    send(1, 32'h0000_004C, 32'h1111_1111, 1'b0, 1'b0, n);
    base = rsp_cnt[1];
    send(1, 32'h0000_0058, 32'h200b_002a, 1'b0, 1'b1, n);
    idle(1);
    repeat (8) @(negedge clk);
    chk("flush_single_rsp", rsp_cnt[1] - base, 1);

    // Write-first collision on the capture edge, then a misaligned write that must be dropped.
    @(negedge clk);
    req_valid[0] = 1'b1; req_addr[0] = 32'h0000_0028; exp_i[0] = 32'h2011_0063; exp_e[0] = 1'b0;
    wr_en = 1'b1; wr_addr = 32'h0000_0028; wr_data = 32'h2011_0063;
    @(negedge clk);
    req_valid[0] = 1'b0; wr_en = 1'b0;
    wr(32'h0000_002A, 32'hbadb_ad00);
    send(0, 32'h0000_0028, 32'h2011_0063, 1'b0, 1'b0, n);
    idle(0);
    repeat (3) @(negedge clk);

    // Reset in the middle of a LATENCY=4 wait.
    send(2, 32'h0000_003C, 32'h0800_0011, 1'b0, 1'b0, n);
    idle(2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid_now", {29'd0, rsp_valid}, 32'd0);
    chk("rst_ready_now", {31'd0, req_ready[2]}, 32'd0);
    base = rsp_cnt[2];
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_midrst", {31'd0, req_ready[2]}, 32'd1);
    repeat (8) @(negedge clk);
    chk("no_stale_rsp", rsp_cnt[2] - base, 0);

    // LATENCY=4 timing after the reset.
    send(2, 32'h0000_0058, 32'h200b_002a, 1'b0, 1'b0, n);
    measure(2, cyc, low);
    chk("l4_latency", cyc, 4);
    chk("l4_ready_low_cycles", low, 3);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
